hp_tracker: RTL and testbench

- Upstream stage of the HP-bar overlay. Owns both players' hit points and applies damage from hit events.
- Enforces a per-player invulnerability window after each applied hit.
- Publishes frame-synchronised HP values (hp_our_state / hp_enemy_state) so bars never tear mid-frame; the overlay derives game_end from them.

---
 rtl/hp_tracker.sv | 139 +++++++++++++
 tb/tb_hp_tracker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_tracker.sv
// Owns both players' HP, applies hit damage with a per-player invulnerability window, publishes HP at vblank.
// Latency: hit_ack one cycle after the hit; published HP up to one frame + 1 cycle; no backpressure, hits are pulses.
module hp_tracker #(
    parameter int HP_MAX       = 200,
    parameter int INVUL_CYCLES = 65000000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       select,
    input  logic       restart,
    input  logic       hit_our,
    input  logic       hit_enemy,
    input  logic [7:0] damage_our,
    input  logic [7:0] damage_enemy,
    output logic [7:0] hp_our_state,
    output logic [7:0] hp_enemy_state,
    output logic       hit_ack_our,
    output logic       hit_ack_enemy,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [7:0]       HP_FULL = 8'(HP_MAX);
    localparam logic [CNT_W-1:0] INVUL   = CNT_W'(INVUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [7:0]       hp_our;
    logic [7:0]       hp_enemy;
    logic [CNT_W-1:0] cnt_our;
    logic [CNT_W-1:0] cnt_enemy;
    logic             vblnk_d;

    logic             vblnk_rise;
    logic             acc_our;
    logic             acc_enemy;
    logic [7:0]       hp_our_nx;
    logic [7:0]       hp_enemy_nx;

    always_comb begin
        vblnk_rise  = vblnk & ~vblnk_d;
        acc_our     = (state == PLAY) && select && hit_our
                      && (cnt_our == '0) && (hp_our != 8'd0);
        acc_enemy   = (state == PLAY) && select && hit_enemy
                      && (cnt_enemy == '0) && (hp_enemy != 8'd0);
        hp_our_nx   = hp_our;
        hp_enemy_nx = hp_enemy;
        // Damage saturates at zero instead of wrapping.
        if (acc_our)
            hp_our_nx = (damage_our >= hp_our) ? 8'd0 : hp_our - damage_our;
        if (acc_enemy)
            hp_enemy_nx = (damage_enemy >= hp_enemy) ? 8'd0 : hp_enemy - damage_enemy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hp_our         <= HP_FULL;
            hp_enemy       <= HP_FULL;
            hp_our_state   <= HP_FULL;
            hp_enemy_state <= HP_FULL;
            cnt_our        <= '0;
            cnt_enemy      <= '0;
            hit_ack_our    <= 1'b0;
            hit_ack_enemy  <= 1'b0;
            game_over      <= 1'b0;
            vblnk_d        <= 1'b0;
        end else begin
            vblnk_d       <= vblnk;
            hit_ack_our   <= acc_our;
            hit_ack_enemy <= acc_enemy;

            // Invulnerability keeps counting down in every state; IDLE overrides below.
            if (acc_our)
                cnt_our <= INVUL;
            else if (cnt_our != '0)
                cnt_our <= cnt_our - CNT_ONE;
            if (acc_enemy)
                cnt_enemy <= INVUL;
            else if (cnt_enemy != '0)
                cnt_enemy <= cnt_enemy - CNT_ONE;

            // Publish the pre-update HP; the reinit paths below take priority.
            if (vblnk_rise) begin
                hp_our_state   <= hp_our;
                hp_enemy_state <= hp_enemy;
            end

            case (state)
                IDLE: begin
                    hp_our    <= HP_FULL;
                    hp_enemy  <= HP_FULL;
                    cnt_our   <= '0;
                    cnt_enemy <= '0;
                    game_over <= 1'b0;
                    if (select)
                        state <= PLAY;
                end
                PLAY: begin
                    if (!select) begin
                        state          <= IDLE;
                        hp_our         <= HP_FULL;
                        hp_enemy       <= HP_FULL;
                        hp_our_state   <= HP_FULL;
                        hp_enemy_state <= HP_FULL;
                        cnt_our        <= '0;
                        cnt_enemy      <= '0;
                        game_over      <= 1'b0;
                    end else begin
                        hp_our   <= hp_our_nx;
                        hp_enemy <= hp_enemy_nx;
                        if ((hp_our_nx == 8'd0) || (hp_enemy_nx == 8'd0)) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (restart || !select) begin
                        state          <= IDLE;
                        hp_our         <= HP_FULL;
                        hp_enemy       <= HP_FULL;
                        hp_our_state   <= HP_FULL;
                        hp_enemy_state <= HP_FULL;
                        cnt_our        <= '0;
                        cnt_enemy      <= '0;
                        game_over      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    game_over <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hp_tracker.sv
// Directed plus randomized bench for hp_tracker against a timestamp-based reference model.
module tb_hp_tracker;
    localparam int INV = 4;
    localparam int HPM = 200;
    localparam int NEVER = -1000;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk = 1'b0;
    logic       select = 1'b0;
    logic       restart = 1'b0;
    logic       hit_our = 1'b0;
    logic       hit_enemy = 1'b0;
    logic [7:0] damage_our = 8'd0;
    logic [7:0] damage_enemy = 8'd0;
    logic [7:0] hp_our_state;
    logic [7:0] hp_enemy_state;
    logic       hit_ack_our;
    logic       hit_ack_enemy;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    // Reference model: game mode, HP values and the cycle of each player's last accepted hit.
    int m_mode, m_cyc;
    int m_hp_our, m_hp_enemy, m_pub_our, m_pub_enemy;
    int m_last_our, m_last_enemy;
    bit m_ack_our, m_ack_enemy, m_vprev;

    hp_tracker #(.HP_MAX(HPM), .INVUL_CYCLES(INV), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .select(select), .restart(restart),
        .hit_our(hit_our), .hit_enemy(hit_enemy),
        .damage_our(damage_our), .damage_enemy(damage_enemy),
        .hp_our_state(hp_our_state), .hp_enemy_state(hp_enemy_state),
        .hit_ack_our(hit_ack_our), .hit_ack_enemy(hit_ack_enemy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_hp_our = HPM; m_hp_enemy = HPM;
        m_pub_our = HPM; m_pub_enemy = HPM;
        m_last_our = NEVER; m_last_enemy = NEVER;
        m_ack_our = 0; m_ack_enemy = 0; m_vprev = 0;
        m_cyc = 0;
    endtask

    task automatic model_reinit();
        m_mode = M_IDLE;
        m_hp_our = HPM; m_hp_enemy = HPM;
        m_pub_our = HPM; m_pub_enemy = HPM;
        m_last_our = NEVER; m_last_enemy = NEVER;
    endtask

    task automatic model_step();
        bit rise;
        bit acc_o, acc_e;
        rise = vblnk && !m_vprev;
        m_vprev = vblnk;
        m_ack_our = 0; m_ack_enemy = 0;
        case (m_mode)
            M_IDLE: begin
                m_last_our = NEVER; m_last_enemy = NEVER;
                if (rise) begin m_pub_our = m_hp_our; m_pub_enemy = m_hp_enemy; end
                if (select) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (!select) model_reinit();
                else begin
                    if (rise) begin m_pub_our = m_hp_our; m_pub_enemy = m_hp_enemy; end
                    acc_o = hit_our && (m_cyc - m_last_our > INV) && (m_hp_our > 0);
                    acc_e = hit_enemy && (m_cyc - m_last_enemy > INV) && (m_hp_enemy > 0);
                    if (acc_o) begin
                        m_hp_our = (int'(damage_our) >= m_hp_our) ? 0 : m_hp_our - int'(damage_our);
                        m_last_our = m_cyc; m_ack_our = 1;
                    end
                    if (acc_e) begin
                        m_hp_enemy = (int'(damage_enemy) >= m_hp_enemy) ? 0 : m_hp_enemy - int'(damage_enemy);
                        m_last_enemy = m_cyc; m_ack_enemy = 1;
                    end
                    if (m_hp_our == 0 || m_hp_enemy == 0) m_mode = M_OVER;
                end
            end
            default: begin
                if (restart || !select) model_reinit();
                else if (rise) begin m_pub_our = m_hp_our; m_pub_enemy = m_hp_enemy; end
            end
        endcase
        m_cyc++;
    endtask

    // One clock: advance the model on the current inputs, then compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("hp_our_state", hp_our_state, m_pub_our);
        chk("hp_enemy_state", hp_enemy_state, m_pub_enemy);
        chk("hit_ack_our", hit_ack_our, m_ack_our);
        chk("hit_ack_enemy", hit_ack_enemy, m_ack_enemy);
        chk("game_over", game_over, m_mode == M_OVER);
    endtask

    task automatic pulse(input bit ho, input int dmo, input bit he, input int dme);
        hit_our = ho; damage_our = 8'(dmo);
        hit_enemy = he; damage_enemy = 8'(dme);
        tick();
        hit_our = 0; hit_enemy = 0;
    endtask

    task automatic frame();
        vblnk = 1; tick();
        vblnk = 0; tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hp_our"}, hp_our_state, HPM);
        chk({tag, "_hp_enemy"}, hp_enemy_state, HPM);
        chk({tag, "_ack_our"}, hit_ack_our, 0);
        chk({tag, "_ack_enemy"}, hit_ack_enemy, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    initial begin
        model_reset();
        #2 rst = 1;
        #1 chk_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        chk_reset_outputs("reset_release");

        // Enemy hit: ack next cycle, publish only at the next vblank rise.
        select = 1; tick();
        pulse(0, 0, 1, 30);
        chk("enemy_ack", hit_ack_enemy, 1);
        chk("enemy_pub_held", hp_enemy_state, 200);
        tick();
        frame();
        chk("enemy_pub_170", hp_enemy_state, 170);

        // Invulnerability window: +2 and +4 rejected, +5 accepted.
        pulse(1, 10, 0, 0);
        chk("our_ack_first", hit_ack_our, 1);
        tick();
        pulse(1, 10, 0, 0);
        chk("our_ack_plus2", hit_ack_our, 0);
        tick();
        pulse(1, 10, 0, 0);
        chk("our_ack_plus4", hit_ack_our, 0);
        pulse(1, 10, 0, 0);
        chk("our_ack_plus5", hit_ack_our, 1);
        frame();
        chk("our_pub_180", hp_our_state, 180);

        // Saturating kill, frozen OVER, restart.
        repeat (5) tick();
        pulse(0, 0, 1, 150);
        repeat (5) tick();
        pulse(0, 0, 1, 50);
        chk("kill_game_over", game_over, 1);
        frame();
        chk("kill_pub_sat0", hp_enemy_state, 0);
        repeat (5) tick();
        pulse(1, 10, 1, 10);
        chk("over_no_ack_our", hit_ack_our, 0);
        chk("over_no_ack_enemy", hit_ack_enemy, 0);
        restart = 1; tick(); restart = 0;
        chk("restart_hp_our", hp_our_state, 200);
        chk("restart_hp_enemy", hp_enemy_state, 200);
        chk("restart_game_over", game_over, 0);
        tick();

        // Draw: both at 10, simultaneous lethal hits.
        pulse(1, 190, 1, 190);
        repeat (5) tick();
        pulse(1, 10, 1, 10);
        chk("draw_ack_our", hit_ack_our, 1);
        chk("draw_ack_enemy", hit_ack_enemy, 1);
        chk("draw_game_over", game_over, 1);
        frame();
        chk("draw_pub_our", hp_our_state, 0);
        chk("draw_pub_enemy", hp_enemy_state, 0);

        // Deselect mid-PLAY clears HP and invulnerability.
        select = 0; tick();
        select = 1; tick();
        pulse(1, 80, 0, 0);
        frame();
        chk("mid_pub_120", hp_our_state, 120);
        repeat (3) tick();
        pulse(1, 0, 0, 0);
        chk("zero_dmg_ack", hit_ack_our, 1);
        select = 0; tick();
        chk("desel_hp_our", hp_our_state, 200);
        chk("desel_game_over", game_over, 0);
        pulse(1, 10, 0, 0);
        chk("desel_no_ack", hit_ack_our, 0);
        select = 1; tick();
        pulse(1, 10, 0, 0);
        chk("desel_invul_cleared", hit_ack_our, 1);

        // Async reset during invulnerability with a vblank rise pending.
        frame();
        chk("pre_reset_pub", hp_our_state, 190);
        repeat (5) tick();
        pulse(0, 0, 1, 20);
        vblnk = 1;
        #2 rst = 1;
        #1 chk_reset_outputs("async_reset");
        @(posedge clk); @(posedge clk); #2;
        rst = 0;
        model_reset();
        tick();
        vblnk = 0;
        pulse(1, 5, 0, 0);
        chk("post_reset_ack", hit_ack_our, 1);

        // Randomized phase against the model.
        for (int i = 0; i < 1500; i++) begin
            vblnk   = (i % 13) < 3;
            select  = ($urandom_range(0, 63) != 0);
            restart = ($urandom_range(0, 15) == 0);
            hit_our   = ($urandom_range(0, 2) == 0);
            hit_enemy = ($urandom_range(0, 2) == 0);
            damage_our   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            damage_enemy = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
